// File: rtl/spike_count_classifier_pkg.sv
// Shared types and helpers for the spike count classifier.
// Package name: spike_cls_pkg.
package spike_cls_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_NUM_OUTPUTS     = 10;
    localparam int DEF_CLASS_WIDTH     = 4;
    localparam int DEF_COUNT_WIDTH     = 8;
    localparam int DEF_WINDOW_CYCLES   = 100;
    localparam int DEF_WINDOW_WIDTH    = 16;
    localparam int DEF_EARLY_THRESHOLD = 50;

    // Increment that sticks at max_value instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/spike_count_classifier_sat_counter.sv
// Per-neuron saturating spike counter (module spike_sat_counter).
// count_next exposes the value the counter will take at the next edge.
module spike_sat_counter
    import spike_cls_pkg::*;
#(
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   inc,
    output logic [COUNT_WIDTH-1:0] count,
    output logic [COUNT_WIDTH-1:0] count_next
);

    localparam logic [31:0] COUNT_MAX = 32'((64'd1 << COUNT_WIDTH) - 64'd1);

    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (inc) begin
            count_next = COUNT_WIDTH'(sat_inc(32'(count), COUNT_MAX));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/spike_count_classifier.sv
// Counts spikes per output neuron over a window and reports the argmax class.
// Optional early exit on a hot neuron: define SPIKE_CLS_EARLY_EXIT_EN.
//
// state | meaning
// IDLE  | waiting for start; last result held on the outputs
// COUNT | accumulating spike_in into the per-neuron counters
// SCAN  | walking the counters one index per cycle, tracking the maximum
// DONE  | result_valid high until the consumer takes it
module spike_count_classifier
    import spike_cls_pkg::*;
#(
    parameter int NUM_OUTPUTS     = DEF_NUM_OUTPUTS,
    parameter int CLASS_WIDTH     = DEF_CLASS_WIDTH,
    parameter int COUNT_WIDTH     = DEF_COUNT_WIDTH,
    parameter int WINDOW_CYCLES   = DEF_WINDOW_CYCLES,
    parameter int WINDOW_WIDTH    = DEF_WINDOW_WIDTH,
    parameter int EARLY_THRESHOLD = DEF_EARLY_THRESHOLD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NUM_OUTPUTS-1:0] spike_in,
    output logic                   busy,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [CLASS_WIDTH-1:0] result_class,
    output logic [COUNT_WIDTH-1:0] result_count,
    output logic                   no_spike
);

    state_t                                   state;
    logic [WINDOW_WIDTH-1:0]                  timer;
    logic [CLASS_WIDTH-1:0]                   scan_idx;
    logic [CLASS_WIDTH-1:0]                   best_idx;
    logic [COUNT_WIDTH-1:0]                   best_count;
    logic [NUM_OUTPUTS-1:0][COUNT_WIDTH-1:0]  counts;
    logic [NUM_OUTPUTS-1:0][COUNT_WIDTH-1:0]  counts_next;
    logic                                     counter_clear;
    logic [NUM_OUTPUTS-1:0]                   counter_inc;
    logic                                     window_end;
    logic                                     early_hit;
    logic                                     last_idx;
    logic                                     cand_gt;
    logic [COUNT_WIDTH-1:0]                   scan_value;
    logic [CLASS_WIDTH-1:0]                   win_idx;
    logic [COUNT_WIDTH-1:0]                   win_count;

    assign counter_clear = (state == IDLE) && start;
    assign counter_inc   = (state == COUNT) ? spike_in : '0;

    for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_cnt
        spike_sat_counter #(
            .COUNT_WIDTH(COUNT_WIDTH)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .clear     (counter_clear),
            .inc       (counter_inc[i]),
            .count     (counts[i]),
            .count_next(counts_next[i])
        );
    end

`ifdef SPIKE_CLS_EARLY_EXIT_EN
    // Looks at the post-update value so the exit cycle's spikes are included.
    always_comb begin
        early_hit = 1'b0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (32'(counts_next[i]) >= 32'(EARLY_THRESHOLD)) begin
                early_hit = 1'b1;
            end
        end
    end
`else
    logic unused_early;
    assign unused_early = ^{counts_next, 32'(EARLY_THRESHOLD)};
    assign early_hit    = 1'b0;
`endif

    assign window_end = (timer == WINDOW_WIDTH'(WINDOW_CYCLES - 1));
    assign last_idx   = (scan_idx == CLASS_WIDTH'(NUM_OUTPUTS - 1));
    assign scan_value = counts[scan_idx];
    // Strictly greater keeps the lowest index on ties.
    assign cand_gt    = (scan_value > best_count);
    assign win_idx    = cand_gt ? scan_idx : best_idx;
    assign win_count  = cand_gt ? scan_value : best_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            scan_idx     <= '0;
            best_idx     <= '0;
            best_count   <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_class <= '0;
            result_count <= '0;
            no_spike     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= COUNT;
                        busy  <= 1'b1;
                        timer <= '0;
                    end
                end
                COUNT: begin
                    if (window_end || early_hit) begin
                        state      <= SCAN;
                        scan_idx   <= '0;
                        best_idx   <= '0;
                        best_count <= '0;
                    end else begin
                        timer <= timer + WINDOW_WIDTH'(1);
                    end
                end
                SCAN: begin
                    best_idx   <= win_idx;
                    best_count <= win_count;
                    scan_idx   <= scan_idx + CLASS_WIDTH'(1);
                    if (last_idx) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        result_class <= win_idx;
                        result_count <= win_count;
                        no_spike     <= (win_count == '0);
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state        <= IDLE;
                        result_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_count_classifier.sv
// Randomized self-checking bench for spike_count_classifier against a window-level model.
// Honours SPIKE_CLS_EARLY_EXIT_EN in the reference model when the RTL is built with it.
module tb_spike_count_classifier;

    localparam int N    = 10;
    localparam int W_A  = 100;
    localparam int W_B  = 300;
    localparam int CMAX = 255;
    localparam int THR  = 50;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         result_ready;
    logic [N-1:0] spike_in;

    logic       busy_a, valid_a, nsp_a;
    logic [3:0] cls_a;
    logic [7:0] cnt_a;
    logic       busy_b, valid_b, nsp_b;
    logic [3:0] cls_b;
    logic [7:0] cnt_b;

    bit         sel_long = 1'b0;
    logic       obs_busy, obs_valid, obs_nsp;
    logic [3:0] obs_cls;
    logic [7:0] obs_cnt;

    assign obs_busy  = sel_long ? busy_b  : busy_a;
    assign obs_valid = sel_long ? valid_b : valid_a;
    assign obs_nsp   = sel_long ? nsp_b   : nsp_a;
    assign obs_cls   = sel_long ? cls_b   : cls_a;
    assign obs_cnt   = sel_long ? cnt_b   : cnt_a;

    int n_checks = 0;
    int n_pass   = 0;
    logic [N-1:0] pat[$];

    always #5 clk = ~clk;

    spike_count_classifier dut_a (
        .clk(clk), .rst(rst), .start(start), .spike_in(spike_in),
        .busy(busy_a), .result_valid(valid_a), .result_ready(result_ready),
        .result_class(cls_a), .result_count(cnt_a), .no_spike(nsp_a)
    );

    spike_count_classifier #(.WINDOW_CYCLES(W_B)) dut_b (
        .clk(clk), .rst(rst), .start(start), .spike_in(spike_in),
        .busy(busy_b), .result_valid(valid_b), .result_ready(result_ready),
        .result_class(cls_b), .result_count(cnt_b), .no_spike(nsp_b)
    );

    // Window-level reference: per-neuron totals, then first index holding the max.
    task automatic model(input int window, output int e_cls, output int e_cnt,
                         output bit e_ns, output int e_len);
        int c[N];
        bit stop;
        for (int i = 0; i < N; i++) c[i] = 0;
        e_len = window;
        stop  = 1'b0;
        for (int t = 0; t < window && !stop; t++) begin
            for (int i = 0; i < N; i++)
                if (pat[t][i]) c[i] = (c[i] + 1 > CMAX) ? CMAX : c[i] + 1;
`ifdef SPIKE_CLS_EARLY_EXIT_EN
            for (int i = 0; i < N; i++)
                if (c[i] >= THR) stop = 1'b1;
            if (stop) e_len = t + 1;
`endif
        end
        e_cls = 0;
        e_cnt = 0;
        for (int i = 0; i < N; i++)
            if (c[i] > e_cnt) begin
                e_cnt = c[i];
                e_cls = i;
            end
        e_ns = (e_cnt == 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; result_ready = 1'b0; spike_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one classification from the current pattern and checks the result.
    task automatic run_window(input string name, input int window, input bit long_dut,
                              input bit noisy_start, input int hold, input bit poke_start);
        int e_cls, e_cnt, e_len, cyc;
        bit e_ns, seen;
        sel_long = long_dut;
        model(window, e_cls, e_cnt, e_ns, e_len);
        @(negedge clk);
        start = 1'b1; spike_in = N'($urandom); result_ready = 1'b0;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < window + N + 20) begin
            @(negedge clk);
            cyc++;
            if (obs_valid) seen = 1'b1;
            else begin
                if (cyc == 1) begin
                    n_checks++;
                    if (obs_busy !== 1'b1) $display("FAIL %s busy_in_count: got %b expected 1", name, obs_busy);
                    else n_pass++;
                end
                start    = noisy_start ? 1'($urandom) : 1'b0;
                spike_in = (cyc - 1 < pat.size()) ? pat[cyc - 1] : N'($urandom);
            end
        end
        start = 1'b0; spike_in = '0;
        n_checks++;
        if (!seen || cyc != e_len + N + 1)
            $display("FAIL %s latency: got valid=%b at cycle %0d expected cycle %0d", name, seen, cyc, e_len + N + 1);
        else n_pass++;
        n_checks++;
        if (obs_cls !== 4'(e_cls)) $display("FAIL %s class: got %0d expected %0d", name, obs_cls, e_cls);
        else n_pass++;
        n_checks++;
        if (obs_cnt !== 8'(e_cnt)) $display("FAIL %s count: got %0d expected %0d", name, obs_cnt, e_cnt);
        else n_pass++;
        n_checks++;
        if (obs_nsp !== e_ns || obs_busy !== 1'b0)
            $display("FAIL %s no_spike/busy: got %b/%b expected %b/0", name, obs_nsp, obs_busy, e_ns);
        else n_pass++;
        for (int h = 1; h <= hold; h++) begin
            start = poke_start && (h == 5);
            @(negedge clk);
            n_checks++;
            if (obs_valid !== 1'b1 || obs_cls !== 4'(e_cls) || obs_cnt !== 8'(e_cnt) || obs_busy !== 1'b0)
                $display("FAIL %s hold%0d: got v=%b c=%0d n=%0d b=%b expected v=1 c=%0d n=%0d b=0",
                         name, h, obs_valid, obs_cls, obs_cnt, obs_busy, e_cls, e_cnt);
            else n_pass++;
        end
        result_ready = 1'b1;
        start        = poke_start;
        @(negedge clk);
        result_ready = 1'b0;
        start        = 1'b0;
        n_checks++;
        if (obs_valid !== 1'b0 || obs_busy !== 1'b0 || obs_cls !== 4'(e_cls) || obs_cnt !== 8'(e_cnt))
            $display("FAIL %s after_handshake: got v=%b b=%b c=%0d n=%0d expected v=0 b=0 c=%0d n=%0d",
                     name, obs_valid, obs_busy, obs_cls, obs_cnt, e_cls, e_cnt);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (obs_busy !== 1'b0) $display("FAIL %s idle_after_handshake: busy got %b expected 0", name, obs_busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        sel_long = 1'b0;
        n_checks++;
        if ({busy_a, valid_a, cls_a, cnt_a, nsp_a} !== 15'd0)
            $display("FAIL reset_state: got b=%b v=%b c=%0d n=%0d z=%b expected all 0", busy_a, valid_a, cls_a, cnt_a, nsp_a);
        else n_pass++;
    endtask

    task automatic test_single_neuron();
        do_reset();
        pat.delete();
        for (int t = 0; t < W_A; t++) pat.push_back(N'(1 << 3));
        run_window("single_n3", W_A, 1'b0, 1'b1, 0, 1'b0);
    endtask

    task automatic test_tie();
        int idx2[$], idx7[$];
        do_reset();
        pat.delete();
        for (int t = 0; t < W_A; t++) pat.push_back('0);
        for (int t = 0; t < W_A; t++) begin idx2.push_back(t); idx7.push_back(t); end
        idx2.shuffle(); idx7.shuffle();
        for (int k = 0; k < 40; k++) begin
            pat[idx2[k]][2] = 1'b1;
            pat[idx7[k]][7] = 1'b1;
        end
        run_window("tie_2_7", W_A, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_no_spike();
        do_reset();
        pat.delete();
        for (int t = 0; t < W_A; t++) pat.push_back('0);
        run_window("no_spike", W_A, 1'b0, 1'b1, 0, 1'b0);
    endtask

    task automatic test_random();
        int dens[N];
        logic [N-1:0] v;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int i = 0; i < N; i++) dens[i] = $urandom_range(0, 60);
            pat.delete();
            for (int t = 0; t < W_A; t++) begin
                v = '0;
                for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 99) < dens[i]);
                pat.push_back(v);
            end
            run_window("random", W_A, 1'b0, 1'b1, 0, 1'b0);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        pat.delete();
        for (int t = 0; t < W_B; t++) pat.push_back(N'(1 << 5));
        run_window("saturate_n5", W_B, 1'b1, 1'b0, 0, 1'b0);
        sel_long = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        pat.delete();
        for (int t = 0; t < W_A; t++) pat.push_back(N'($urandom));
        run_window("backpressure", W_A, 1'b0, 1'b0, 20, 1'b1);
        pat.delete();
        for (int t = 0; t < W_A; t++) pat.push_back(N'(1 << 8) | (t % 3 == 0 ? N'(1 << 1) : '0));
        run_window("restart", W_A, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int cyc;
        do_reset();
        sel_long = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) begin spike_in = N'($urandom); @(negedge clk); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (busy_a !== 1'b0 || valid_a !== 1'b0)
            $display("FAIL reset_mid_count: got busy=%b valid=%b expected 0/0", busy_a, valid_a);
        else n_pass++;
        spike_in = N'(1 << 4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!valid_a && cyc < W_A + N + 20) begin @(negedge clk); cyc++; end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (valid_a !== 1'b0 || cls_a !== 4'd0 || cnt_a !== 8'd0 || cyc >= W_A + N + 20)
            $display("FAIL reset_in_done: got v=%b c=%0d n=%0d wait=%0d expected v=0 c=0 n=0", valid_a, cls_a, cnt_a, cyc);
        else n_pass++;
        spike_in = '0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; result_ready = 1'b0; spike_in = '0;
        test_reset();
        test_single_neuron();
        test_tie();
        test_no_spike();
        test_random();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spike_count_classifier.md
Name: spike_count_classifier

Overview:
- Sits directly downstream of the integrate-and-fire network.
- Counts output spikes per neuron over a fixed window of timesteps, then scans the counts and reports the winning class index.
- The winner is the neuron with the most spikes. A valid/ready handshake presents the result to the host/readout logic.

Parameters:
- NUM_OUTPUTS, 10, number of output neurons (spike_in width).
- CLASS_WIDTH, 4, width of class index; must satisfy 2^CLASS_WIDTH >= NUM_OUTPUTS.
- COUNT_WIDTH, 8, width of each per-neuron saturating spike counter.
- WINDOW_CYCLES, 100, number of counting cycles per classification; must be >= 1.
- WINDOW_WIDTH, 16, width of window timer; must satisfy 2^WINDOW_WIDTH > WINDOW_CYCLES.
- EARLY_THRESHOLD, 50, count that triggers early exit (used only with the optional feature).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse beginning a classification window; honoured only in IDLE.
- spike_in  input  NUM_OUTPUTS  per-cycle spike vector from the network.
- busy  output  1  high in COUNT and SCAN.
- result_valid  output  1  result available.
- result_ready  input  1  consumer accepts result.
- result_class  output  CLASS_WIDTH  winning neuron index.
- result_count  output  COUNT_WIDTH  spike count of the winner.
- no_spike  output  1  all counters were zero at scan end.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; all counters, window timer and scan index = 0.
  - busy, result_valid, result_class, result_count and no_spike = 0.
  - Reset in any state aborts the operation the next edge; a pending result is discarded.
- FSM states: IDLE, COUNT, SCAN, DONE.
- IDLE:
  - On start=1: clear all counters and the timer, then go to COUNT.
  - spike_in in the start cycle is not counted.
- COUNT:
  - Each cycle, counter[i] += spike_in[i]; counters saturate at 2^COUNT_WIDTH-1 (no wrap).
  - The timer increments each cycle. After exactly WINDOW_CYCLES counted cycles, go to SCAN.
  - start is ignored.
- SCAN:
  - Scans index 0..NUM_OUTPUTS-1, one per cycle, over NUM_OUTPUTS cycles.
  - The best value/index update only on strictly greater count, so ties resolve to the lowest index.
  - spike_in is ignored.
  - After the last index, go to DONE.
- DONE:
  - result_valid=1; result_class, result_count and no_spike are stable while valid.
  - If all counts are 0: no_spike=1, result_class=0, result_count=0.
  - On result_valid&&result_ready: go to IDLE the next cycle; result_valid drops and output data is held until the next DONE.
  - start asserted in DONE is ignored, even in the same cycle as the handshake.
- Latency: start at cycle T → counting in T+1..T+WINDOW_CYCLES → scan in T+WINDOW_CYCLES+1..T+WINDOW_CYCLES+NUM_OUTPUTS → result_valid high from T+WINDOW_CYCLES+NUM_OUTPUTS+1.
- Back-pressure: DONE holds indefinitely while result_ready=0.

Optional Feature:
- Macro SPIKE_CLS_EARLY_EXIT_EN.
- Defined:
  - In COUNT, if any counter's updated value reaches >= EARLY_THRESHOLD, the FSM goes to SCAN at the next edge regardless of the timer.
  - The spikes of that cycle are included in the counts.
- Undefined: EARLY_THRESHOLD is unused and the window always runs the full WINDOW_CYCLES.

Decomposition:
- Shared package spike_cls_pkg:
  - FSM state encoding (IDLE=0, COUNT=1, SCAN=2, DONE=3).
  - Default width constants.
  - A function computing saturating increment.
- Sub-module spike_sat_counter (COUNT_WIDTH param; clear, inc, count out, saturating), instantiated NUM_OUTPUTS times in a generate loop.
- FSM, timer and argmax scan stay in the top.

Test Plan:
- Defaults; neuron 3 spikes every cycle, others never → result_class=3, result_count=100, no_spike=0, result_valid at start+111.
- Neurons 2 and 7 both spike 40 times → result_class=2 (tie to lowest), result_count=40.
- spike_in all zero for the window → no_spike=1, result_class=0, result_count=0.
- Neuron 5 spikes every cycle with WINDOW_CYCLES=300 → count saturates at 255, no wrap; class 5.
- result_ready low for 20 cycles after valid; start pulsed during DONE → outputs stable, start ignored. Handshake → IDLE; a fresh start then works.
- rst asserted mid-COUNT → next cycle IDLE, busy=0, result_valid=0. With SPIKE_CLS_EARLY_EXIT_EN and neuron 0 spiking every cycle → SCAN entered after the 50th counted cycle, result_count=50.
